uart_tx_sched: RTL and testbench



---
 rtl/uart_tx_sched.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ requesters.
// Each grant sends one frame: sync byte, requester id, then payload bytes LSB first.
module uart_tx_sched #(
  parameter int         NREQ          = 4,
  parameter int         MSG_BYTES     = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         START_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*MSG_BYTES*8-1:0] req_data,
  output logic [NREQ-1:0]             req_ack,
  output logic                        uart_transmit,
  output logic [7:0]                  uart_tx_byte,
  input  logic                        uart_is_transmitting,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        tx_err
);
  localparam int PW = MSG_BYTES * 8;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      id_q, id_d;
  logic [4:0]      byte_idx_q, byte_idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [PW-1:0]   buf_q, buf_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            uart_transmit_q, uart_transmit_d;
  logic [7:0]      uart_tx_byte_q, uart_tx_byte_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            tx_err_q, tx_err_d;

  logic            found;
  logic [2:0]      win;
  logic [PW-1:0]   win_data;
  logic [7:0]      cur_byte;
  logic [TW-1:0]   tmo_inc;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    cur_byte = SYNC_BYTE;
    tmo_inc  = (tmo_q == TW'(START_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);

    // Search above rr_ptr first, then wrap to the lowest set bit (rr_ptr itself comes last).
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (3'(i) > rr_ptr_q)) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) win_data = req_data[i*PW +: PW];
    end

    if (byte_idx_q == 5'd1) cur_byte = {5'b0, id_q};
    for (int k = 0; k < MSG_BYTES; k++) begin
      if (byte_idx_q == 5'(k + 2)) cur_byte = buf_q[k*8 +: 8];
    end

    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    id_d            = id_q;
    byte_idx_d      = byte_idx_q;
    tmo_d           = tmo_q;
    buf_d           = buf_q;
    req_ack_d       = '0;
    uart_transmit_d = 1'b0;
    uart_tx_byte_d  = uart_tx_byte_q;
    busy_d          = busy_q;
    frame_done_d    = 1'b0;
    tx_err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          buf_d      = win_data;
          id_d       = win;
          rr_ptr_d   = win;
          req_ack_d  = NREQ'(1) << win;
          byte_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!uart_is_transmitting) begin
          uart_tx_byte_d  = cur_byte;
          uart_transmit_d = 1'b1;
          tmo_d           = '0;
          state_d         = WAIT_START;
        end
      end
      WAIT_START: begin
        if (uart_is_transmitting) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_inc;
          // The UART never picked the byte up; retry the same byte from SEND.
          if (tmo_inc == TW'(START_TIMEOUT)) begin
            tx_err_d = 1'b1;
            state_d  = SEND;
          end
        end
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          if (byte_idx_q == 5'(MSG_BYTES + 1)) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 5'd1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= 3'(NREQ - 1);
      id_q            <= '0;
      byte_idx_q      <= '0;
      tmo_q           <= '0;
      buf_q           <= '0;
      req_ack_q       <= '0;
      uart_transmit_q <= 1'b0;
      uart_tx_byte_q  <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      tx_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      id_q            <= id_d;
      byte_idx_q      <= byte_idx_d;
      tmo_q           <= tmo_d;
      buf_q           <= buf_d;
      req_ack_q       <= req_ack_d;
      uart_transmit_q <= uart_transmit_d;
      uart_tx_byte_q  <= uart_tx_byte_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      tx_err_q        <= tx_err_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign uart_transmit = uart_transmit_q;
  assign uart_tx_byte  = uart_tx_byte_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign tx_err        = tx_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a UART responder plus a frame-level reference model
// (round-robin winner prediction, expected byte list) under directed and random traffic.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  localparam int NREQ          = 4;
  localparam int MSG_BYTES     = 4;
  localparam int START_TIMEOUT = 16;
  localparam int PW            = MSG_BYTES * 8;
  localparam int FRAME_LEN     = MSG_BYTES + 2;
  localparam int DW            = NREQ * PW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [DW-1:0]   req_data = '0;
  logic [NREQ-1:0] req_ack;
  logic            uart_transmit;
  logic [7:0]      uart_tx_byte;
  logic            uart_is_transmitting;
  logic            busy;
  logic            frame_done;
  logic            tx_err;

  logic            model_tx = 1'b0;
  logic            bp_force = 1'b0;
  int              hold_cycles = 3;
  int              ignore_n = 0;
  int              model_cnt = 0;
  int              cyc = 0;
  int              tx_pulses = 0;
  int              err_count = 0;
  int              fd_count = 0;
  int              last_pulse_cyc = 0;
  int              err_gap = 0;
  int              overlap_count = 0;
  int              onehot_bad = 0;
  int              proto_bad = 0;
  int              ack_count[NREQ] = '{default: 0};
  logic [7:0]      got_q[$];

  int              vectors = 0;
  int              miscompares = 0;
  int              model_rr = NREQ - 1;
  int              frames_ok = 0;
  int              grants = 0;
  logic [NREQ-1:0] cur_mask = '0;
  logic [DW-1:0]   cur_data = '0;

  assign uart_is_transmitting = model_tx | bp_force;

  uart_tx_sched #(
    .NREQ(NREQ), .MSG_BYTES(MSG_BYTES), .SYNC_BYTE(8'hA5), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting), .busy(busy),
    .frame_done(frame_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  // UART responder and event monitor: accepts a byte on a transmit pulse (unless told to
  // ignore it), raises is_transmitting on the following cycle and holds it hold_cycles cycles.
  always @(negedge clk) begin
    cyc++;
    if (tx_err) begin
      err_count++;
      err_gap = cyc - last_pulse_cyc;
    end
    if (frame_done) fd_count++;
    if (frame_done && (req_ack != '0)) overlap_count++;
    if ($countones(req_ack) > 1) onehot_bad++;
    for (int i = 0; i < NREQ; i++) if (req_ack[i]) ack_count[i]++;
    if (uart_transmit) begin
      tx_pulses++;
      last_pulse_cyc = cyc;
      if (uart_is_transmitting) proto_bad++;
    end
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_tx = 1'b0;
    end
    if (uart_transmit) begin
      if (ignore_n > 0) ignore_n--;
      else begin
        got_q.push_back(uart_tx_byte);
        model_tx  = 1'b1;
        model_cnt = hold_cycles;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [DW-1:0] data);
    req      = mask;
    req_data = data;
    cur_mask = mask;
    cur_data = data;
  endtask

  function automatic int predictWinner(input logic [NREQ-1:0] mask);
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (model_rr + off) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput("reset_outputs",
                  64'({req_ack, uart_transmit, uart_tx_byte, busy, frame_done, tx_err}), 64'd0);
    end
    rst_n    = 1'b1;
    model_rr = NREQ - 1;
  endtask

  // One frame: expect the ack for the predicted winner, apply the next request set right
  // after the ack, then compare the bytes the UART accepted against the expected frame.
  task automatic runFrame(input string tag, input logic [NREQ-1:0] nxt_mask,
                          input logic [DW-1:0] nxt_data, input int ign, input int bp_cycles);
    int            exp_id;
    logic [PW-1:0] exp_pay;
    logic [7:0]    exp_bytes[FRAME_LEN];
    int            pulses0;
    int            errs0;
    bit            seen;
    exp_id = predictWinner(cur_mask);
    if (exp_id < 0) begin
      checkOutput({tag, "_no_req"}, 64'd0, 64'd1);
      return;
    end
    exp_pay      = cur_data[exp_id*PW +: PW];
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'(exp_id);
    for (int b = 0; b < MSG_BYTES; b++) exp_bytes[b+2] = exp_pay[b*8 +: 8];
    pulses0  = tx_pulses;
    errs0    = err_count;
    ignore_n = ign;
    if (bp_cycles > 0) bp_force = 1'b1;

    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      if (req_ack != '0) seen = 1'b1;
    end
    checkOutput({tag, "_ack"}, 64'(req_ack), 64'(1 << exp_id));
    if (!seen) begin
      bp_force = 1'b0;
      return;
    end
    grants++;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    model_rr = exp_id;
    applyStimulus(nxt_mask, nxt_data);

    if (bp_cycles > 0) begin
      repeat (bp_cycles) @(negedge clk);
      checkOutput({tag, "_bp_hold"}, 64'(tx_pulses - pulses0), 64'd0);
      bp_force = 1'b0;
    end

    seen = 1'b0;
    for (int w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    checkOutput({tag, "_done"}, 64'(seen), 64'd1);
    if (!seen) return;
    frames_ok++;
    checkOutput({tag, "_len"}, 64'(got_q.size()), 64'(FRAME_LEN));
    for (int b = 0; b < FRAME_LEN; b++) begin
      logic [7:0] g;
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checkOutput($sformatf("%s_byte%0d", tag, b), 64'(g), 64'(exp_bytes[b]));
    end
    got_q.delete();
    checkOutput({tag, "_pulses"}, 64'(tx_pulses - pulses0), 64'(FRAME_LEN + ign));
    checkOutput({tag, "_tx_err"}, 64'(err_count - errs0), 64'(ign));
    if (ign > 0) checkOutput({tag, "_tmo_gap"}, 64'(err_gap), 64'(START_TIMEOUT));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap[NREQ];
    bit seen;
    doReset(3);

    // Single request with a slow UART.
    hold_cycles = 40;
    applyStimulus(4'b0001, {96'h0, 32'h11223344});
    runFrame("single", 4'b0000, {96'h0, 32'h11223344}, 0, 0);
    repeat (10) @(negedge clk);
    checkOutput("single_busy_after", 64'(busy), 64'd0);
    checkOutput("single_ack_count", 64'(ack_count[0]), 64'd1);
    checkOutput("single_fd_count", 64'(fd_count), 64'd1);
    checkOutput("single_total_pulses", 64'(tx_pulses), 64'(FRAME_LEN));

    // Three requesters held together: order 0,1,3 twice from reset.
    doReset(2);
    hold_cycles = 3;
    for (int i = 0; i < NREQ; i++) snap[i] = ack_count[i];
    applyStimulus(4'b1011, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    for (int f = 0; f < 6; f++)
      runFrame($sformatf("simul%0d", f), (f == 5) ? 4'b0000 : 4'b1011, cur_data, 0, 0);
    checkOutput("simul_acks0", 64'(ack_count[0] - snap[0]), 64'd2);
    checkOutput("simul_acks1", 64'(ack_count[1] - snap[1]), 64'd2);
    checkOutput("simul_acks2", 64'(ack_count[2] - snap[2]), 64'd0);
    checkOutput("simul_acks3", 64'(ack_count[3] - snap[3]), 64'd2);

    // Payload changed right after the ack must not reach the frame.
    applyStimulus(4'b0100, {32'h0, 32'hCAFEF00D, 64'h0});
    runFrame("payload", 4'b0000, {32'h0, 32'hDEADBEEF, 64'h0}, 0, 0);

    // UART ignores the first transmit pulse: one tx_err, byte retried.
    hold_cycles = 4;
    applyStimulus(4'b0001, {96'h0, 32'h0BADF00D});
    runFrame("timeout", 4'b0000, cur_data, 1, 0);

    // Reset in the middle of byte 3 with requests still held.
    got_q.delete();
    hold_cycles = 5;
    applyStimulus(4'b0111, {32'h0, 32'h77665544, 32'h33221100, 32'hA1B2C3D4});
    seen = 1'b0;
    for (int w = 0; w < 400 && !seen; w++) begin
      @(negedge clk);
      if (got_q.size() >= 4) seen = 1'b1;
    end
    checkOutput("rst_mid_progress", 64'(seen), 64'd1);
    grants++;
    doReset(2);
    got_q.delete();
    runFrame("rst_resume", 4'b0000, cur_data, 0, 0);

    // is_transmitting already high when SEND is entered.
    hold_cycles = 3;
    applyStimulus(4'b0001, {96'h0, 32'h5A5A0F0F});
    runFrame("backpressure", 4'b0000, cur_data, 0, 20);

    // Random traffic against the reference model.
    applyStimulus(4'b1111, {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0] m;
      logic [DW-1:0]   d;
      int              ign;
      int              bp;
      m           = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d           = {$urandom(), $urandom(), $urandom(), $urandom()};
      hold_cycles = $urandom_range(1, 6);
      ign         = ($urandom_range(0, 7) == 0) ? 1 : 0;
      bp          = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 0;
      runFrame($sformatf("rand%0d", r), m, d, ign, bp);
    end
    runFrame("rand_last", 4'b0000, cur_data, 0, 0);

    repeat (20) @(negedge clk);
    checkOutput("final_idle_busy", 64'(busy), 64'd0);
    checkOutput("final_fd_count", 64'(fd_count), 64'(frames_ok));
    checkOutput("final_ack_total",
                64'(ack_count[0] + ack_count[1] + ack_count[2] + ack_count[3]), 64'(grants));
    checkOutput("final_overlap", 64'(overlap_count), 64'd0);
    checkOutput("final_onehot", 64'(onehot_bad), 64'd0);
    checkOutput("final_protocol", 64'(proto_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
